// File: rtl/mem_io_pkg.sv
// Shared constants for the CPU memory/IO bus.
// Address map, FIFO depth and TCTRL layout.
package mem_io_pkg;

  localparam logic [7:0] RAM_TOP     = 8'hEF;
  localparam logic [7:0] ADDR_OUT    = 8'hF0;
  localparam logic [7:0] ADDR_IN     = 8'hF1;
  localparam logic [7:0] ADDR_TCNT   = 8'hF2;
  localparam logic [7:0] ADDR_TCTRL  = 8'hF3;
  localparam logic [7:0] ADDR_TRLD   = 8'hF4;
  localparam logic [7:0] ADDR_TXD    = 8'hF5;
  localparam logic [7:0] ADDR_TXSTAT = 8'hF6;

  localparam int RAM_WORDS = 240;
  localparam int TX_DEPTH  = 4;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AUTO = 1;
  localparam int TCTRL_EXP  = 7;

  typedef struct packed {
    logic exp;
    logic auto_rl;
    logic en;
  } tctrl_t;

  function automatic logic [7:0] tctrl_pack(
    input tctrl_t t
  );
    logic [7:0] v;
    v = '0;
    v[TCTRL_EN]   = t.en;
    v[TCTRL_AUTO] = t.auto_rl;
    v[TCTRL_EXP]  = t.exp;
    return v;
  endfunction

  // A full FIFO reports count bits 00; FULL carries it.
  function automatic logic [7:0] txstat_pack(
    input logic       full,
    input logic       empty,
    input logic       ovf,
    input logic [2:0] cnt
  );
    return {2'b00, cnt[1:0], 1'b0, ovf, empty, full};
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Four-entry transmit FIFO.
// Circular buffer, 2-bit pointers, 3-bit count.
module tx_fifo
  import mem_io_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic       ovf_set,
  output logic [2:0] count
);

  logic [7:0] mem [TX_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] cnt_q;
  logic       do_push;
  logic       do_pop;

  assign full    = (cnt_q == 3'(TX_DEPTH));
  assign empty   = (cnt_q == 3'd0);
  assign count   = cnt_q;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is lost even if a pop frees a slot.
  assign ovf_set = push && full;

  // Storage, pointers and occupancy; reset empties and clears all slots.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < TX_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_bus.sv
// CPU memory and I/O bus: 240-byte RAM plus register page.
// Zero-wait reads, one-edge writes, timer and TX FIFO.
module mem_io_bus
  import mem_io_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] MADDR,
  input  logic       READ,
  input  logic       WRITE,
  input  logic [7:0] DATA_O,
  output logic [7:0] DATA_I,
  input  logic [7:0] IN_PORT,
  output logic [7:0] OUT_PORT,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY,
  output logic       IRQ
);

  logic [7:0] ram [RAM_WORDS];

  logic [7:0] out_q;
  logic [7:0] in_s1;
  logic [7:0] in_s2;
  logic [7:0] tcnt_q;
  logic [7:0] trld_q;
  tctrl_t     tc_q;
  logic       ovf_q;

  logic [7:0] tcnt_d;
  tctrl_t     tc_d;
  logic       exp_set;
  logic       ovf_d;

  logic       is_ram;
  logic       wr_out;
  logic       wr_tcnt;
  logic       wr_tctrl;
  logic       wr_trld;
  logic       wr_txd;
  logic       rd_tctrl;
  logic       rd_txstat;

  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_ovf;
  logic [2:0] fifo_cnt;
  logic       tx_pop;

  logic [7:0] rdata;

  assign is_ram    = (MADDR <= RAM_TOP);
  assign wr_out    = WRITE && (MADDR == ADDR_OUT);
  assign wr_tcnt   = WRITE && (MADDR == ADDR_TCNT);
  assign wr_tctrl  = WRITE && (MADDR == ADDR_TCTRL);
  assign wr_trld   = WRITE && (MADDR == ADDR_TRLD);
  assign wr_txd    = WRITE && (MADDR == ADDR_TXD);
  assign rd_tctrl  = READ && (MADDR == ADDR_TCTRL);
  assign rd_txstat = READ && (MADDR == ADDR_TXSTAT);

  assign TX_VALID = !fifo_empty && !RST;
  assign TX_DATA  = RST ? 8'h00 : fifo_dout;
  assign OUT_PORT = RST ? 8'h00 : out_q;
  assign IRQ      = tc_q.exp && !RST;
  assign tx_pop   = TX_VALID && TX_READY;
  assign DATA_I   = rdata;

  tx_fifo u_tx_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (wr_txd),
    .pop     (tx_pop),
    .din     (DATA_O),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ovf_set (fifo_ovf),
    .count   (fifo_cnt)
  );

  // RAM write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (WRITE && is_ram) begin
      ram[MADDR] <= DATA_O;
    end
  end

  // Timer next state: CPU load, then count down, then expiry.
  always_comb begin
    tcnt_d  = tcnt_q;
    tc_d    = tc_q;
    exp_set = 1'b0;
    if (wr_tcnt) begin
      tcnt_d = DATA_O;
    end else if (tc_q.en && (tcnt_q != 8'd0)) begin
      tcnt_d = tcnt_q - 8'd1;
    end else if (tc_q.en) begin
      exp_set = 1'b1;
      if (tc_q.auto_rl) begin
        tcnt_d = trld_q;
      end else begin
        tc_d.en = 1'b0;
      end
    end
    if (wr_tctrl) begin
      tc_d.en      = DATA_O[TCTRL_EN];
      tc_d.auto_rl = DATA_O[TCTRL_AUTO];
    end
    tc_d.exp = exp_set || (tc_q.exp && !rd_tctrl);
    ovf_d    = fifo_ovf || (ovf_q && !rd_txstat);
  end

  // Register page state and input synchroniser.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q  <= '0;
      in_s1  <= '0;
      in_s2  <= '0;
      tcnt_q <= '0;
      trld_q <= '0;
      tc_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      in_s1  <= IN_PORT;
      in_s2  <= in_s1;
      tcnt_q <= tcnt_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      if (wr_out) begin
        out_q <= DATA_O;
      end
      if (wr_trld) begin
        trld_q <= DATA_O;
      end
    end
  end

  // Combinational read mux; idle bus reads zero.
  always_comb begin
    rdata = 8'h00;
    if (READ) begin
      unique case (1'b1)
        is_ram:                 rdata = ram[MADDR];
        (MADDR == ADDR_OUT):    rdata = out_q;
        (MADDR == ADDR_IN):     rdata = in_s2;
        (MADDR == ADDR_TCNT):   rdata = tcnt_q;
        (MADDR == ADDR_TCTRL):  rdata = tctrl_pack(tc_q);
        (MADDR == ADDR_TRLD):   rdata = trld_q;
        (MADDR == ADDR_TXSTAT): rdata = txstat_pack(fifo_full, fifo_empty,
                                                    ovf_q, fifo_cnt);
        default:                rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_bus.sv
// Directed bench for mem_io_bus.
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_mem_io_bus;

  logic       CLK;
  logic       RST;
  logic [7:0] MADDR;
  logic       READ;
  logic       WRITE;
  logic [7:0] DATA_O;
  logic [7:0] DATA_I;
  logic [7:0] IN_PORT;
  logic [7:0] OUT_PORT;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       IRQ;

  int total;
  int passed;

  mem_io_bus dut (
    .CLK      (CLK),
    .RST      (RST),
    .MADDR    (MADDR),
    .READ     (READ),
    .WRITE    (WRITE),
    .DATA_O   (DATA_O),
    .DATA_I   (DATA_I),
    .IN_PORT  (IN_PORT),
    .OUT_PORT (OUT_PORT),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY),
    .IRQ      (IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic drive(input logic [7:0] a, input logic r,
                       input logic w, input logic [7:0] d);
    @(negedge CLK);
    MADDR  = a;
    READ   = r;
    WRITE  = w;
    DATA_O = d;
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 8'h00);
    drive(8'hF6, 1'b1, 1'b0, 8'h00);
    total++; if (OUT_PORT !== 8'h00) $display("FAIL rst_out got %h want 00", OUT_PORT); else passed++;
    total++; if (TX_VALID !== 1'b0) $display("FAIL rst_txv got %b want 0", TX_VALID); else passed++;
    total++; if (TX_DATA !== 8'h00) $display("FAIL rst_txd got %h want 00", TX_DATA); else passed++;
    total++; if (IRQ !== 1'b0) $display("FAIL rst_irq got %b want 0", IRQ); else passed++;
    total++; if (DATA_I !== 8'h02) $display("FAIL rst_txstat got %h want 02", DATA_I); else passed++;
    RST = 1'b0;
    drive(8'hF3, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h00) $display("FAIL rst_tctrl got %h want 00", DATA_I); else passed++;
    drive(8'hF2, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h00) $display("FAIL rst_tcnt got %h want 00", DATA_I); else passed++;
  endtask

  task automatic test_ram;
    drive(8'h10, 1'b0, 1'b1, 8'hA5);
    drive(8'h10, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'hA5) $display("FAIL ram_rd got %h want a5", DATA_I); else passed++;
    drive(8'h10, 1'b0, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h00) $display("FAIL idle_rd got %h want 00", DATA_I); else passed++;
    drive(8'hF8, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h00) $display("FAIL unmapped_rd got %h want 00", DATA_I); else passed++;
    drive(8'hF9, 1'b0, 1'b1, 8'h55);
    drive(8'hF9, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h00) $display("FAIL unmapped_wr got %h want 00", DATA_I); else passed++;
    drive(8'hEF, 1'b0, 1'b1, 8'h77);
    drive(8'hEF, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h77) $display("FAIL ram_top got %h want 77", DATA_I); else passed++;
    drive(8'h10, 1'b1, 1'b1, 8'h3C);
    total++; if (DATA_I !== 8'hA5) $display("FAIL rw_prewrite got %h want a5", DATA_I); else passed++;
    drive(8'h10, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h3C) $display("FAIL rw_postwrite got %h want 3c", DATA_I); else passed++;
    drive(8'hF0, 1'b0, 1'b1, 8'h5A);
    drive(8'hF0, 1'b1, 1'b0, 8'h00);
    total++; if (OUT_PORT !== 8'h5A) $display("FAIL out_port got %h want 5a", OUT_PORT); else passed++;
    total++; if (DATA_I !== 8'h5A) $display("FAIL out_rd got %h want 5a", DATA_I); else passed++;
  endtask

  task automatic test_in_sync;
    drive(8'hF1, 1'b1, 1'b0, 8'h00);
    IN_PORT = 8'h96;
    drive(8'hF1, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h00) $display("FAIL in_edge1 got %h want 00", DATA_I); else passed++;
    drive(8'hF1, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h96) $display("FAIL in_edge2 got %h want 96", DATA_I); else passed++;
  endtask

  task automatic test_timer_oneshot;
    logic [7:0] exp_cnt [4];
    exp_cnt = '{8'h03, 8'h02, 8'h01, 8'h00};
    drive(8'hF2, 1'b0, 1'b1, 8'h03);
    drive(8'hF3, 1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 4; i++) begin
      drive(8'hF2, 1'b1, 1'b0, 8'h00);
      total++; if (DATA_I !== exp_cnt[i]) $display("FAIL os_tcnt%0d got %h want %h", i, DATA_I, exp_cnt[i]); else passed++;
      total++; if (IRQ !== 1'b0) $display("FAIL os_irq_early%0d got %b want 0", i, IRQ); else passed++;
    end
    drive(8'hF2, 1'b1, 1'b0, 8'h00);
    total++; if (IRQ !== 1'b1) $display("FAIL os_irq got %b want 1", IRQ); else passed++;
    total++; if (DATA_I !== 8'h00) $display("FAIL os_tcnt_hold got %h want 00", DATA_I); else passed++;
    drive(8'hF3, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h80) $display("FAIL os_tctrl got %h want 80", DATA_I); else passed++;
    drive(8'h00, 1'b0, 1'b0, 8'h00);
    total++; if (IRQ !== 1'b0) $display("FAIL os_irq_clr got %b want 0", IRQ); else passed++;
  endtask

  task automatic test_timer_auto;
    drive(8'hF4, 1'b0, 1'b1, 8'h02);
    drive(8'hF2, 1'b0, 1'b1, 8'h00);
    drive(8'hF3, 1'b0, 1'b1, 8'h03);
    drive(8'hF2, 1'b1, 1'b0, 8'h00);
    total++; if (IRQ !== 1'b0) $display("FAIL ar_irq0 got %b want 0", IRQ); else passed++;
    drive(8'hF3, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h83) $display("FAIL ar_tctrl got %h want 83", DATA_I); else passed++;
    total++; if (IRQ !== 1'b1) $display("FAIL ar_irq1 got %b want 1", IRQ); else passed++;
    drive(8'hF2, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h01) $display("FAIL ar_reload got %h want 01", DATA_I); else passed++;
    total++; if (IRQ !== 1'b0) $display("FAIL ar_clr got %b want 0", IRQ); else passed++;
    drive(8'hF3, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h03) $display("FAIL ar_tctrl2 got %h want 03", DATA_I); else passed++;
    drive(8'hF2, 1'b1, 1'b0, 8'h00);
    total++; if (IRQ !== 1'b1) $display("FAIL ar_setwins got %b want 1", IRQ); else passed++;
    total++; if (DATA_I !== 8'h02) $display("FAIL ar_reload2 got %h want 02", DATA_I); else passed++;
    drive(8'hF3, 1'b0, 1'b1, 8'h00);
    drive(8'hF3, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h80) $display("FAIL ar_stop got %h want 80", DATA_I); else passed++;
    drive(8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_fifo_fill;
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    TX_READY = 1'b0;
    drive(8'hF5, 1'b0, 1'b1, 8'h11);
    drive(8'hF5, 1'b0, 1'b1, 8'h22);
    total++; if (TX_VALID !== 1'b1) $display("FAIL ff_valid got %b want 1", TX_VALID); else passed++;
    total++; if (TX_DATA !== 8'h11) $display("FAIL ff_head got %h want 11", TX_DATA); else passed++;
    drive(8'hF5, 1'b0, 1'b1, 8'h33);
    drive(8'hF5, 1'b0, 1'b1, 8'h44);
    drive(8'hF6, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h01) $display("FAIL ff_full got %h want 01", DATA_I); else passed++;
    drive(8'hF5, 1'b0, 1'b1, 8'h55);
    drive(8'hF6, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h05) $display("FAIL ff_ovf got %h want 05", DATA_I); else passed++;
    drive(8'hF6, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h01) $display("FAIL ff_ovf_clr got %h want 01", DATA_I); else passed++;
    drive(8'hF5, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h00) $display("FAIL ff_txd_rd got %h want 00", DATA_I); else passed++;
    total++; if (TX_DATA !== 8'h11) $display("FAIL ff_stable got %h want 11", TX_DATA); else passed++;
    TX_READY = 1'b1;
    for (int i = 1; i < 4; i++) begin
      drive(8'h00, 1'b0, 1'b0, 8'h00);
      total++; if (TX_DATA !== exp_d[i]) $display("FAIL ff_drain%0d got %h want %h", i, TX_DATA, exp_d[i]); else passed++;
    end
    drive(8'h00, 1'b0, 1'b0, 8'h00);
    total++; if (TX_VALID !== 1'b0) $display("FAIL ff_empty got %b want 0", TX_VALID); else passed++;
    TX_READY = 1'b0;
  endtask

  task automatic test_fifo_concurrency;
    logic [7:0] exp_d [2];
    exp_d = '{8'hA4, 8'hA5};
    drive(8'hF5, 1'b0, 1'b1, 8'hA1);
    drive(8'hF5, 1'b0, 1'b1, 8'hA2);
    drive(8'hF6, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h20) $display("FAIL fc_cnt2 got %h want 20", DATA_I); else passed++;
    drive(8'hF5, 1'b0, 1'b1, 8'hA3);
    TX_READY = 1'b1;
    total++; if (TX_DATA !== 8'hA1) $display("FAIL fc_head got %h want a1", TX_DATA); else passed++;
    drive(8'hF6, 1'b1, 1'b0, 8'h00);
    TX_READY = 1'b0;
    total++; if (DATA_I !== 8'h20) $display("FAIL fc_pushpop got %h want 20", DATA_I); else passed++;
    total++; if (TX_DATA !== 8'hA2) $display("FAIL fc_order got %h want a2", TX_DATA); else passed++;
    drive(8'hF5, 1'b0, 1'b1, 8'hA4);
    drive(8'hF5, 1'b0, 1'b1, 8'hA5);
    drive(8'hF6, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h01) $display("FAIL fc_full got %h want 01", DATA_I); else passed++;
    drive(8'hF5, 1'b0, 1'b1, 8'hA6);
    TX_READY = 1'b1;
    drive(8'hF6, 1'b1, 1'b0, 8'h00);
    TX_READY = 1'b0;
    total++; if (DATA_I !== 8'h34) $display("FAIL fc_full_pop got %h want 34", DATA_I); else passed++;
    total++; if (TX_DATA !== 8'hA3) $display("FAIL fc_head3 got %h want a3", TX_DATA); else passed++;
    TX_READY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(8'h00, 1'b0, 1'b0, 8'h00);
      total++; if (TX_DATA !== exp_d[i]) $display("FAIL fc_drain%0d got %h want %h", i, TX_DATA, exp_d[i]); else passed++;
    end
    drive(8'h00, 1'b0, 1'b0, 8'h00);
    total++; if (TX_VALID !== 1'b0) $display("FAIL fc_empty got %b want 0", TX_VALID); else passed++;
    TX_READY = 1'b0;
  endtask

  task automatic test_reset_mid;
    drive(8'h20, 1'b0, 1'b1, 8'hC3);
    drive(8'hF0, 1'b0, 1'b1, 8'h77);
    drive(8'hF5, 1'b0, 1'b1, 8'hB1);
    drive(8'hF5, 1'b0, 1'b1, 8'hB2);
    drive(8'hF5, 1'b0, 1'b1, 8'hB3);
    drive(8'hF2, 1'b0, 1'b1, 8'h50);
    drive(8'hF3, 1'b0, 1'b1, 8'h01);
    drive(8'hF6, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h30) $display("FAIL rm_cnt3 got %h want 30", DATA_I); else passed++;
    RST = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 8'h00);
    RST = 1'b0;
    drive(8'hF2, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h00) $display("FAIL rm_tcnt got %h want 00", DATA_I); else passed++;
    total++; if (TX_VALID !== 1'b0) $display("FAIL rm_txv got %b want 0", TX_VALID); else passed++;
    total++; if (IRQ !== 1'b0) $display("FAIL rm_irq got %b want 0", IRQ); else passed++;
    total++; if (OUT_PORT !== 8'h00) $display("FAIL rm_out got %h want 00", OUT_PORT); else passed++;
    drive(8'hF3, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h00) $display("FAIL rm_tctrl got %h want 00", DATA_I); else passed++;
    drive(8'h20, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'hC3) $display("FAIL rm_ram got %h want c3", DATA_I); else passed++;
    drive(8'h10, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h3C) $display("FAIL rm_ram2 got %h want 3c", DATA_I); else passed++;
    drive(8'hF1, 1'b1, 1'b0, 8'h00);
    total++; if (DATA_I !== 8'h96) $display("FAIL rm_in got %h want 96", DATA_I); else passed++;
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    RST      = 1'b1;
    MADDR    = 8'h00;
    READ     = 1'b0;
    WRITE    = 1'b0;
    DATA_O   = 8'h00;
    IN_PORT  = 8'h00;
    TX_READY = 1'b0;
    test_reset();
    test_ram();
    test_in_sync();
    test_timer_oneshot();
    test_timer_auto();
    test_fifo_fill();
    test_fifo_concurrency();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
